// File: rtl/sram_mem_responder_pkg.sv
// Shared types and constants for the MEM-stage SRAM responder.
// Word-to-half-word split and FSM state encoding live here.
package sram_mem_responder_pkg;

    localparam int unsigned DATA_W            = 32;
    localparam int unsigned SRAM_DATA_W       = 16;
    localparam logic [31:0] DEFAULT_ADDR_BASE = 32'd1024;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Byte offset from the mapped base, modulo 2^32, in 32-bit words.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                               input logic [31:0] base);
        return (byte_addr - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_addr_map.sv
// Byte address to SRAM half-word address translation (combinational).
// Addresses below the base wrap silently; upper word bits are discarded.
module sram_addr_map
    import sram_mem_responder_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = DEFAULT_ADDR_BASE,
    parameter int unsigned SRAM_ADDR_W = 18
) (
    input  logic [31:0]            byte_addr,
    input  logic                   half,
    output logic [SRAM_ADDR_W-1:0] half_addr
);

    logic [31:0] word;
    logic        unused_word_bits;

    always_comb begin
        word      = word_index(byte_addr, ADDR_BASE);
        half_addr = {word[SRAM_ADDR_W-2:0], half};
    end

    assign unused_word_bits = ^word[31:SRAM_ADDR_W-1];

endmodule

// File: rtl/sram_mem_responder.sv
// MEM-stage data memory responder: one 32-bit load/store carried out as
// two 16-bit accesses on an asynchronous SRAM; ready stays low until done.
module sram_mem_responder
    import sram_mem_responder_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = DEFAULT_ADDR_BASE,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MEM_R_ENIn,
    input  logic                   MEM_W_ENIn,
    input  logic [31:0]            addressIn,
    input  logic [31:0]            writeDataIn,
    output logic [31:0]            readDataOut,
    output logic                   readyOut,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
);

    localparam int unsigned     CNT_W    = $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_t                   state;
    logic [CNT_W-1:0]         counter;
    logic [CNT_W-1:0]         cnt_inc;
    logic [15:0]              wdata_hi;
    logic [SRAM_ADDR_W-1:0]   lo_addr;
    logic                     req;

    sram_addr_map #(
        .ADDR_BASE   (ADDR_BASE),
        .SRAM_ADDR_W (SRAM_ADDR_W)
    ) u_addr_map (
        .byte_addr (addressIn),
        .half      (1'b0),
        .half_addr (lo_addr)
    );

    always_comb begin
        req      = MEM_R_ENIn | MEM_W_ENIn;
        readyOut = ~req | (state == DONE);
        cnt_inc  = counter + 1'b1;
    end

    // Address and high data half are latched at acceptance so a request
    // withdrawn mid-access still finishes as one coherent word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            counter     <= '0;
            readDataOut <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            wdata_hi    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    counter <= '0;
                    if (MEM_W_ENIn) begin
                        state       <= WR_LO;
                        sram_addr   <= lo_addr;
                        sram_dq_out <= writeDataIn[15:0];
                        wdata_hi    <= writeDataIn[31:16];
                        sram_dq_oe  <= 1'b1;
                        sram_we_n   <= 1'b0;
                    end else if (MEM_R_ENIn) begin
                        state     <= RD_LO;
                        sram_addr <= lo_addr;
                    end
                end
                RD_LO, RD_HI, WR_LO, WR_HI: begin
                    if (counter == CNT_LAST) begin
                        counter <= '0;
                        if (state == RD_LO) begin
                            readDataOut[15:0] <= sram_dq_in;
                            sram_addr         <= {sram_addr[SRAM_ADDR_W-1:1], 1'b1};
                            state             <= RD_HI;
                        end else if (state == RD_HI) begin
                            readDataOut[31:16] <= sram_dq_in;
                            state              <= DONE;
                        end else if (state == WR_LO) begin
                            sram_addr   <= {sram_addr[SRAM_ADDR_W-1:1], 1'b1};
                            sram_dq_out <= wdata_hi;
                            sram_we_n   <= 1'b0;
                            state       <= WR_HI;
                        end else begin
                            sram_dq_oe <= 1'b0;
                            sram_we_n  <= 1'b1;
                            state      <= DONE;
                        end
                    end else begin
                        counter <= cnt_inc;
                        // Strobe released on the last cycle of each half for hold.
                        if (state == WR_LO || state == WR_HI) begin
                            sram_we_n <= (cnt_inc == CNT_LAST);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_responder.sv
// Scoreboard bench for sram_mem_responder: randomized loads/stores against
// a word-level memory model, plus a WAIT_CYCLES=3 latency instance.
module tb_sram_mem_responder;

    localparam int unsigned W    = 2;
    localparam logic [31:0] BASE = 32'd1024;
    localparam int unsigned LAT  = 1 + 2 * W;

    logic        clk;
    logic        rst;
    logic        rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] dq_out, dq_in;
    logic        dq_oe, we_n;

    logic        rd3;
    logic [31:0] addr3, rdata3;
    logic        ready3;
    logic [17:0] sram_addr3;
    logic [15:0] dq_out3, dq_in3;
    logic        dq_oe3, we_n3;

    bit [15:0]   sram_mem [0:262143];
    int unsigned cyc;
    int unsigned n_checks, n_pass;

    typedef struct {
        bit          is_wr;
        int unsigned issue;
        logic [31:0] exp_rd;
        logic [31:0] wdata;
        logic [17:0] lo;
    } txn_t;

    txn_t        sb[$];
    bit [31:0]   ref_mem [int unsigned];
    logic [31:0] last_read;
    int unsigned issue3, n3;

    sram_mem_responder #(
        .ADDR_BASE   (BASE),
        .WAIT_CYCLES (W),
        .SRAM_ADDR_W (18)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .MEM_R_ENIn  (rd),
        .MEM_W_ENIn  (wr),
        .addressIn   (addr),
        .writeDataIn (wdata),
        .readDataOut (rdata),
        .readyOut    (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (dq_out),
        .sram_dq_in  (dq_in),
        .sram_dq_oe  (dq_oe),
        .sram_we_n   (we_n)
    );

    sram_mem_responder #(
        .ADDR_BASE   (BASE),
        .WAIT_CYCLES (3),
        .SRAM_ADDR_W (18)
    ) dut3 (
        .clk         (clk),
        .rst         (rst),
        .MEM_R_ENIn  (rd3),
        .MEM_W_ENIn  (1'b0),
        .addressIn   (addr3),
        .writeDataIn (32'h0),
        .readDataOut (rdata3),
        .readyOut    (ready3),
        .sram_addr   (sram_addr3),
        .sram_dq_out (dq_out3),
        .sram_dq_in  (dq_in3),
        .sram_dq_oe  (dq_oe3),
        .sram_we_n   (we_n3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Asynchronous SRAM: reads are combinational, writes land while we_n is low.
    assign dq_in  = sram_mem[sram_addr];
    assign dq_in3 = {8'hA5, sram_addr3[7:0]};
    always @(posedge clk) begin
        if (rst && !we_n && dq_oe) sram_mem[sram_addr] <= dq_out;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [17:0] ref_lo(input logic [31:0] a);
        logic [31:0] w;
        w = (a - BASE) / 4;
        return 18'((w % 131072) * 2);
    endfunction

    task automatic issue(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
        txn_t        t;
        int unsigned key;
        int unsigned n;
        @(posedge clk);
        #1;
        key = ((a - BASE) / 4) % 131072;
        if (w) ref_mem[key] = d;
        else   last_read = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
        t.is_wr  = w;
        t.issue  = cyc;
        t.exp_rd = last_read;
        t.wdata  = d;
        t.lo     = ref_lo(a);
        sb.push_back(t);
        wr    = w;
        rd    = r;
        addr  = a;
        wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 100);
        if (!ready) chk("timeout", {31'h0, ready}, 32'h1);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rd = 1'b0;
            wr = 1'b0;
        end
    endtask

    // Monitor: pops the expected response whenever the DUT completes a request.
    initial begin
        txn_t        t;
        logic [17:0] a1, a2;
        int unsigned we_low;
        we_low = 0;
        a1 = '0;
        a2 = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                we_low = 0;
                continue;
            end
            if (!we_n) we_low++;
            if (sb.size() > 0 && (rd || wr)) begin
                if (cyc == sb[0].issue + 1)     a1 = sram_addr;
                if (cyc == sb[0].issue + 2 * W) a2 = sram_addr;
            end
            if ((rd || wr) && ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", sb.size(), 1);
                end else begin
                    t = sb.pop_front();
                    chk("latency",   cyc - t.issue, LAT);
                    chk("read_data", rdata, t.exp_rd);
                    chk("addr_lo",   {14'h0, a1}, {14'h0, t.lo});
                    chk("addr_hi",   {14'h0, a2}, {14'h0, t.lo | 18'h1});
                    if (t.is_wr) begin
                        chk("sram_lo", {16'h0, sram_mem[t.lo]}, {16'h0, t.wdata[15:0]});
                        chk("sram_hi", {16'h0, sram_mem[t.lo | 18'h1]}, {16'h0, t.wdata[31:16]});
                        chk("we_low_cycles", we_low, 2 * (W - 1));
                    end else begin
                        chk("we_low_cycles", we_low, 0);
                        chk("read_oe", {31'h0, dq_oe}, 32'h0);
                    end
                    we_low = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass = 0;
        last_read = '0;
        rst = 1'b0;
        rd = 1'b0;
        wr = 1'b0;
        addr = '0;
        wdata = '0;
        rd3 = 1'b0;
        addr3 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata",  rdata, 32'h0);
        chk("rst_addr",   {14'h0, sram_addr}, 32'h0);
        chk("rst_dq_out", {16'h0, dq_out}, 32'h0);
        chk("rst_oe",     {31'h0, dq_oe}, 32'h0);
        chk("rst_we_n",   {31'h0, we_n}, 32'h1);
        chk("rst_ready",  {31'h0, ready}, 32'h1);
        rst = 1'b1;

        // Reset asserted while the low half of a write is in progress.
        @(posedge clk);
        #1;
        wr = 1'b1;
        addr = BASE + 32'd4000;
        wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        chk("midwr_we_active", {31'h0, we_n}, 32'h0);
        rst = 1'b0;
        wr = 1'b0;
        #1;
        chk("midwr_rst_we_n",  {31'h0, we_n}, 32'h1);
        chk("midwr_rst_oe",    {31'h0, dq_oe}, 32'h0);
        chk("midwr_rst_ready", {31'h0, ready}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        issue(1'b1, 1'b0, BASE, 32'hDEAD_BEEF);
        issue(1'b0, 1'b1, BASE, 32'h0);
        idle(1);
        issue(1'b0, 1'b1, BASE + 32'd12, 32'h0);
        issue(1'b0, 1'b1, BASE - 32'd4, 32'h0);
        idle(2);
        issue(1'b0, 1'b1, BASE + 32'd4, 32'h0);
        issue(1'b1, 1'b0, BASE + 32'd8, 32'hCAFE_F00D);
        issue(1'b1, 1'b1, BASE + 32'd16, 32'h0BAD_1DEA);
        issue(1'b0, 1'b1, BASE + 32'd8, 32'h0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            int unsigned op;
            op = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) a = BASE - 32'($urandom_range(1, 4) * 4);
            else a = BASE + 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            issue(op != 0, op != 1, a, $urandom);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(2);

        // Slower instance: three cycles per half-word.
        @(posedge clk);
        #1;
        rd3 = 1'b1;
        addr3 = BASE + 32'd8;
        issue3 = cyc;
        n3 = 0;
        do begin
            @(negedge clk);
            n3++;
        end while (!ready3 && n3 < 100);
        chk("w3_latency", cyc - issue3, 32'd7);
        chk("w3_rdata",   rdata3, 32'hA505_A504);
        chk("w3_addr",    {14'h0, sram_addr3}, 32'd5);
        chk("w3_we_n",    {31'h0, we_n3}, 32'h1);
        chk("w3_oe",      {31'h0, dq_oe3}, 32'h0);
        chk("w3_dq_out",  {16'h0, dq_out3}, 32'h0);
        @(posedge clk);
        #1;
        rd3 = 1'b0;

        chk("scoreboard_drained", sb.size(), 0);
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_mem_responder.md
Name: sram_mem_responder

Overview:
- Responder at the data-memory end of the MEM stage. It accepts one 32-bit load or store request from the pipeline's MEM stage.
- Each word is carried out as two 16-bit half-word accesses on an external asynchronous SRAM.
- It drives `ready` low until the access completes; the top level derives the pipeline freeze from `~ready`.
- It replaces the single-cycle data memory on the MEM-stage side.

Parameters:
- ADDR_BASE, 1024, byte address mapped to SRAM word 0.
- WAIT_CYCLES, 2, cycles each half-word access is held; must be >= 2.
- SRAM_ADDR_W, 18, SRAM half-word address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (rst=0 resets).
- MEM_R_ENIn  in  1  load request from MEM stage.
- MEM_W_ENIn  in  1  store request from MEM stage.
- addressIn  in  32  byte address (ALU result).
- writeDataIn  in  32  store data (Val_Rm).
- readDataOut  out  32  load data, registered.
- readyOut  out  1  1 = no request pending, or current request completes this cycle.
- sram_addr  out  SRAM_ADDR_W  half-word address.
- sram_dq_out  out  16  write data to SRAM.
- sram_dq_in  in  16  read data from SRAM.
- sram_dq_oe  out  1  1 = controller drives the DQ bus (writes only).
- sram_we_n  out  1  SRAM write strobe, active-low.

Behaviour:
- Reset values:
  - state=IDLE, counter=0, readDataOut=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
  - readyOut follows the combinational rule below, so it is 1 with no request.
- Address mapping:
  - word = (addressIn - ADDR_BASE) >> 2, 32-bit modulo subtraction.
  - sram_addr = {word[SRAM_ADDR_W-2:0], half}; half=0 is the low half-word, half=1 the high.
  - Addresses below ADDR_BASE wrap. No error is raised.
- Request arbitration:
  - req = MEM_R_ENIn | MEM_W_ENIn.
  - If both are asserted, the write wins.
- readyOut = ~req | (state==DONE), combinational.
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
  - IDLE: req with write -> WR_LO; req with read only -> RD_LO; no req -> stay; counter=0.
  - RD_LO / RD_HI / WR_LO / WR_HI: counter runs 0..WAIT_CYCLES-1. At counter==WAIT_CYCLES-1: counter=0 and advance LO->HI, HI->DONE.
  - DONE: lasts exactly one cycle, then -> IDLE. The pipeline advances at the DONE edge; the next request is accepted only from IDLE. A back-to-back request therefore costs one IDLE cycle and the completed request is never re-issued.
- Read:
  - On the last counter cycle of RD_LO, capture sram_dq_in into readDataOut[15:0].
  - On the last counter cycle of RD_HI, capture sram_dq_in into readDataOut[31:16].
  - readDataOut is valid from DONE and holds until the next read completes. Writes do not change it.
  - sram_dq_oe=0 and sram_we_n=1 throughout.
- Write:
  - sram_dq_oe=1 in WR_LO/WR_HI.
  - sram_dq_out = writeDataIn[15:0] in WR_LO, writeDataIn[31:16] in WR_HI.
  - sram_we_n=0 while counter < WAIT_CYCLES-1, then 1 on the last cycle of each half (address/data hold).
- Latency:
  - Request asserted in cycle 0 (IDLE) gives readyOut=1 in cycle 1+2*WAIT_CYCLES.
  - With defaults, ready is high in cycle 5.
- Request withdrawn mid-access (only possible on reset or branch flush):
  - The access runs to DONE anyway.
  - Any write always completes both halves, so there are no torn words.
- Reset mid-operation: immediate return to IDLE with sram_we_n=1 and sram_dq_oe=0. A partial write may be left in the SRAM; this is acceptable.
- Outputs to the SRAM are registered. Nothing in the block is combinational from sram_dq_in to readDataOut.

Decomposition:
- Shared package: state encoding (3-bit localparams for IDLE..DONE), ADDR_BASE default, data width 32, SRAM data width 16.
- One natural sub-module, sram_addr_map: combinational byte-address to half-word-address translation, reused by the testbench model.
- The FSM and datapath stay in sram_mem_responder.

Test Plan:
- Reset: rst=0 mid-WR_LO -> next cycle sram_we_n=1, sram_dq_oe=0, state IDLE, readyOut=1 with no request.
- Store then load:
  - Store: write 0xDEADBEEF to address 1024 -> SRAM model half-word 0 = 0xBEEF and half-word 1 = 0xDEAD; readyOut low in cycles 0-4, high in cycle 5.
  - Load: read from 1024 -> readDataOut=0xDEADBEEF in DONE.
- Address mapping: read from 1036 -> sram_addr 6 then 7; read from 1020 (below base) -> wrapped address, completes normally with no hang.
- Back-to-back: load at 1028 immediately followed by store to 1032 -> second access starts after one IDLE cycle; each completes exactly once (count sram_we_n low pulses = 2*(WAIT_CYCLES-1)).
- Conflict and timing:
  - MEM_R_ENIn and MEM_W_ENIn both 1 -> write performed, readDataOut unchanged.
  - WAIT_CYCLES=3 -> readyOut high in cycle 7.
